// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one adjust+shift step per clock,
// with valid/ready handshakes, leading-zero blanking and overflow reporting.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [BIN_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_acc;
  logic             ovf_acc;

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_nxt;
  logic [BIN_W-1:0] sh_nxt;
  logic             ovf_nxt;

  // Per-digit add-3 for digits >= 5; digits are independent, no carry between them.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Bit i set when digit i and every higher digit are zero; the ones digit is never blanked.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [BCD_W-1:0] d);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (d[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  always_comb begin
    bcd_adj = add3_digits(bcd_acc);
    bcd_nxt = {bcd_adj[BCD_W-2:0], shreg[BIN_W-1]};
    sh_nxt  = shreg << 1;
    // The bit leaving the top digit is a dropped multiple of 10^DIGITS.
    ovf_nxt = ovf_acc | bcd_adj[BCD_W-1];
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      bcd_acc  <= '0;
      ovf_acc  <= 1'b0;
      bcd_out  <= '0;
      blank    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg   <= bin_in;
            bcd_acc <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= sh_nxt;
          bcd_acc <= bcd_nxt;
          ovf_acc <= ovf_nxt;
          cnt     <= cnt - CNT_W'(1);
          // Results are published only on the final step so outputs hold while converting.
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            bcd_out  <= bcd_nxt;
            blank    <= lz_mask(bcd_nxt);
            overflow <= ovf_nxt;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq: a 16-bit/5-digit instance and an
// 8-bit/2-digit instance (overflow range), checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 16-bit / 5-digit instance
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, overflow_a;
  logic [15:0] bin_a;
  logic [19:0] bcd_a;
  logic [4:0]  blank_a;

  // 8-bit / 2-digit instance
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, overflow_b;
  logic [7:0]  bin_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .bin_in(bin_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .bcd_out(bcd_a), .blank(blank_a), .overflow(overflow_a)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .bin_in(bin_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .bcd_out(bcd_b), .blank(blank_b), .overflow(overflow_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: value modulo 10^digits, packed one decimal digit per nibble.
  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [63:0] ref_bcd(input longint v, input int digits);
    logic [63:0] r = '0;
    longint x = v % pow10(digits);
    for (int i = 0; i < digits; i++) begin
      r = r | (64'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_blank(input longint v, input int digits);
    logic [63:0] r = '0;
    longint x = v % pow10(digits);
    for (int i = 1; i < digits; i++) r[i] = (x < pow10(i));
    return r;
  endfunction

  function automatic logic [63:0] ref_ovf(input longint v, input int digits);
    return {63'd0, (v >= pow10(digits))};
  endfunction

  logic [19:0] prev_bcd_a = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion on the 16-bit instance with `hold` cycles of backpressure in DONE.
  // Spurious in_valid pulses and bin_in changes are injected while busy.
  task automatic run_a(input logic [15:0] v, input int hold);
    int cyc;
    cyc = 0;
    while (!in_ready_a && cyc < 100) begin tick(); cyc++; end
    chk("a_in_ready", {63'd0, in_ready_a}, 64'd1);
    in_valid_a = 1'b1;
    bin_a      = v;
    tick();
    cyc = 0;
    while (!out_valid_a && cyc < 100) begin
      in_valid_a = 1'($urandom_range(0, 1));
      bin_a      = 16'($urandom);
      if (cyc == 8) chk("a_hold_shift", 64'(bcd_a), 64'(prev_bcd_a));
      tick();
      cyc++;
    end
    chk("a_latency", 64'(cyc), 64'd16);
    chk("a_bcd", 64'(bcd_a), ref_bcd(longint'(v), 5));
    chk("a_blank", 64'(blank_a), ref_blank(longint'(v), 5));
    chk("a_ovf", {63'd0, overflow_a}, ref_ovf(longint'(v), 5));
    for (int k = 0; k < hold; k++) begin
      in_valid_a = 1'($urandom_range(0, 1));
      bin_a      = 16'($urandom);
      tick();
    end
    in_valid_a = 1'b0;
    if (hold > 0) begin
      chk("a_bp_valid", {63'd0, out_valid_a}, 64'd1);
      chk("a_bp_ready", {63'd0, in_ready_a}, 64'd0);
      chk("a_bp_bcd", 64'(bcd_a), ref_bcd(longint'(v), 5));
      chk("a_bp_blank", 64'(blank_a), ref_blank(longint'(v), 5));
    end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk("a_release", {62'd0, out_valid_a, in_ready_a}, 64'd1);
    prev_bcd_a = bcd_a;
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  q[$];
    logic [7:0]  e;
    int cyc, last, sent, recv, seen_valid;

    rst_n = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; bin_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; bin_b = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a", {41'd0, out_valid_a, in_ready_a, overflow_a, blank_a, bcd_a}, {41'd0, 1'b0, 1'b1, 1'b0, 5'd0, 20'd0});
    chk("rst_b", {51'd0, out_valid_b, in_ready_b, overflow_b, blank_b, bcd_b}, {51'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0});
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Corner values, then random operands with random backpressure.
    run_a(16'd0, 0);
    run_a(16'd65535, 10);
    run_a(16'd1000, 3);
    run_a(16'd9, 0);
    run_a(16'd10, 1);
    for (int t = 0; t < 20; t++) begin
      v = 16'($urandom);
      run_a(v, $urandom_range(0, 10));
    end

    // Reset while the counter reads 7 (nine steps after accept) discards the conversion.
    in_valid_a = 1'b1;
    bin_a      = 16'd54321;
    tick();
    in_valid_a = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {41'd0, out_valid_a, overflow_a, blank_a, bcd_a}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready_a}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (out_valid_a) seen_valid = 1;
    end
    chk("mid_rst_novalid", 64'(seen_valid), 64'd0);
    chk("mid_rst_idle", {63'd0, in_ready_a}, 64'd1);
    prev_bcd_a = '0;
    run_a(16'd42, 2);
    chk("a_42", 64'(bcd_a), 64'h00042);
    chk("a_42_blank", 64'(blank_a), 64'b11100);

    // Exhaustive streaming on the 8-bit instance: out_ready tied high, one result per 10 clocks.
    out_ready_b = 1'b1;
    in_valid_b  = 1'b1;
    bin_b       = 8'd0;
    cyc = 0; last = -1; sent = 0; recv = 0;
    while (recv < 256 && cyc < 5000) begin
      if (out_valid_b) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b_bcd", 64'(bcd_b), ref_bcd(longint'(e), 2));
          chk("b_blank", 64'(blank_b), ref_blank(longint'(e), 2));
          chk("b_ovf", {63'd0, overflow_b}, ref_ovf(longint'(e), 2));
        end else begin
          chk("b_spurious_valid", 64'd1, 64'd0);
        end
        if (last >= 0) chk("b_interval", 64'(cyc - last), 64'd10);
        last = cyc;
        recv++;
      end
      if (in_ready_b && in_valid_b) begin
        q.push_back(bin_b);
        sent++;
      end
      tick();
      cyc++;
      if (sent >= 256) in_valid_b = 1'b0;
      else bin_b = 8'(sent);
    end
    chk("b_count", 64'(recv), 64'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
